// File: rtl/frame_rx.sv
// frame_rx: receive-side parser for the length-prefixed byte-push protocol.
// A header byte carries the payload length in bits [2:0]. The remaining header
// bits must be zero. Payload bytes go into a first-word-fall-through FIFO. Each
// completed frame is reported with its length and, optionally, its XOR checksum.
//
// Optional feature macro: FRM_RX_XOR_EN. When defined, the payload XOR accumulator
// is built. When undefined, frm_xor is tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, idata         producer byte strobe and byte (header or payload)
//   not_full            FIFO holds fewer than DEPTH entries
//   pop, rdy, odata     consumer pop, FIFO non-empty, FIFO head
//   frm_valid           one-cycle pulse at frame completion
//   frm_len, frm_xor    length / payload XOR of the last completed frame
//   hdr_err             one-cycle pulse when a malformed header is discarded
//   ovf_err             sticky: a payload byte arrived while the FIFO was full
module frame_rx #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] idata,
  output logic       not_full,
  input  logic       pop,
  output logic       rdy,
  output logic [7:0] odata,
  output logic       frm_valid,
  output logic [2:0] frm_len,
  output logic [7:0] frm_xor,
  output logic       hdr_err,
  output logic       ovf_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [0:0] {StHdr, StPay} state_e;

  state_e         state_q;
  logic [2:0]     len_q;
  logic [2:0]     idx_q;
  logic           frm_valid_q;
  logic [2:0]     frm_len_q;
  logic           hdr_err_q;
  logic           ovf_err_q;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic           wr_en;
  logic           rd_en;
  logic           last_byte;

  // Status is derived from the registered count only.
  assign not_full  = (cnt_q != CW'(DEPTH));
  assign rdy       = (cnt_q != '0);
  assign odata     = rdy ? mem[rd_ptr_q] : 8'h00;

  // Headers never enter the FIFO; payload only enters when not full.
  assign wr_en     = push && (state_q == StPay) && not_full;
  assign rd_en     = pop && rdy;
  assign last_byte = (idx_q + 3'd1 == len_q);

  assign frm_valid = frm_valid_q;
  assign frm_len   = frm_len_q;
  assign hdr_err   = hdr_err_q;
  assign ovf_err   = ovf_err_q;

`ifdef FRM_RX_XOR_EN
  logic [7:0] acc_q;
  logic [7:0] acc_nxt;
  logic [7:0] frm_xor_q;

  // Dropped (overflow) bytes are excluded from the checksum.
  always_comb begin
    acc_nxt = acc_q;
    if (not_full) begin
      acc_nxt = acc_q ^ idata;
    end
  end

  assign frm_xor = frm_xor_q;
`else
  assign frm_xor = 8'h00;
`endif

  // Frame parser FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHdr;
      len_q       <= 3'd0;
      idx_q       <= 3'd0;
      frm_valid_q <= 1'b0;
      frm_len_q   <= 3'd0;
      hdr_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
`ifdef FRM_RX_XOR_EN
      acc_q       <= 8'h00;
      frm_xor_q   <= 8'h00;
`endif
    end else begin
      frm_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      if (push) begin
        unique case (state_q)
          StHdr: begin
            if (idata[7:3] != 5'd0) begin
              hdr_err_q <= 1'b1;
            end else if (idata[2:0] == 3'd0) begin
              frm_valid_q <= 1'b1;
              frm_len_q   <= 3'd0;
`ifdef FRM_RX_XOR_EN
              frm_xor_q   <= 8'h00;
`endif
            end else begin
              len_q   <= idata[2:0];
              idx_q   <= 3'd0;
`ifdef FRM_RX_XOR_EN
              acc_q   <= 8'h00;
`endif
              state_q <= StPay;
            end
          end
          StPay: begin
            // The count advances even for dropped bytes so framing stays aligned.
            if (!not_full) begin
              ovf_err_q <= 1'b1;
            end
`ifdef FRM_RX_XOR_EN
            acc_q <= acc_nxt;
`endif
            if (last_byte) begin
              state_q     <= StHdr;
              frm_valid_q <= 1'b1;
              frm_len_q   <= len_q;
`ifdef FRM_RX_XOR_EN
              frm_xor_q   <= acc_nxt;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
          default: state_q <= StHdr;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; odata is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= idata;
    end
  end

endmodule

// File: tb/tb_frame_rx.sv
// Self-checking bench for frame_rx: a table of single-cycle vectors followed by
// hand-written sequences for overflow, full push+pop and mid-frame reset.
module tb_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       push;
  logic [7:0] idata;
  logic       not_full;
  logic       pop;
  logic       rdy;
  logic [7:0] odata;
  logic       frm_valid;
  logic [2:0] frm_len;
  logic [7:0] frm_xor;
  logic       hdr_err;
  logic       ovf_err;

  int checks = 0;
  int errors = 0;

  frame_rx #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .idata     (idata),
    .not_full  (not_full),
    .pop       (pop),
    .rdy       (rdy),
    .odata     (odata),
    .frm_valid (frm_valid),
    .frm_len   (frm_len),
    .frm_xor   (frm_xor),
    .hdr_err   (hdr_err),
    .ovf_err   (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       push;
    logic [7:0] idata;
    logic       pop;
    logic       rdy;
    logic [7:0] odata;
    logic       nf;
    logic       fv;
    logic [2:0] len;
    logic [7:0] xr;
    logic       he;
    logic       ovf;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  // Expected checksum depends on whether the XOR feature is built.
  function automatic logic [7:0] xr(input logic [7:0] v);
`ifdef FRM_RX_XOR_EN
    return v;
`else
    return v & 8'h00;
`endif
  endfunction

  function automatic vec_t mk(input logic p, input logic [7:0] d, input logic pp,
                              input logic r, input logic [7:0] od, input logic nf,
                              input logic fv, input logic [2:0] len, input logic [7:0] x,
                              input logic he, input logic ovf);
    vec_t v;
    v = '{push: p, idata: d, pop: pp, rdy: r, odata: od, nf: nf, fv: fv, len: len,
          xr: x, he: he, ovf: ovf};
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic r, input logic [7:0] od,
                         input logic nf, input logic fv, input logic [2:0] len,
                         input logic [7:0] x, input logic he, input logic ovf);
    chk({tag, ".rdy"},       {7'd0, rdy},       {7'd0, r});
    chk({tag, ".odata"},     odata,             od);
    chk({tag, ".not_full"},  {7'd0, not_full},  {7'd0, nf});
    chk({tag, ".frm_valid"}, {7'd0, frm_valid}, {7'd0, fv});
    chk({tag, ".frm_len"},   {5'd0, frm_len},   {5'd0, len});
    chk({tag, ".frm_xor"},   frm_xor,           x);
    chk({tag, ".hdr_err"},   {7'd0, hdr_err},   {7'd0, he});
    chk({tag, ".ovf_err"},   {7'd0, ovf_err},   {7'd0, ovf});
  endtask

  // Apply inputs for one clock, then sample 1 time unit after the edge.
  task automatic cycle(input logic p, input logic [7:0] d, input logic pp);
    push  = p;
    idata = d;
    pop   = pp;
    @(posedge clk);
    #1;
    push  = 1'b0;
    idata = 8'h00;
    pop   = 1'b0;
  endtask

  initial begin
    int         mcnt;
    logic       movf;
    logic [7:0] macc;
    logic [7:0] j;

    vecs[0]  = mk(1, 8'h03, 0, 0, 8'h00, 1, 0, 3'd0, 8'h00,     0, 0);
    vecs[1]  = mk(1, 8'hA5, 0, 1, 8'hA5, 1, 0, 3'd0, 8'h00,     0, 0);
    vecs[2]  = mk(1, 8'h0F, 0, 1, 8'hA5, 1, 0, 3'd0, 8'h00,     0, 0);
    vecs[3]  = mk(1, 8'h30, 0, 1, 8'hA5, 1, 1, 3'd3, xr(8'h9A), 0, 0);
    vecs[4]  = mk(0, 8'h00, 1, 1, 8'h0F, 1, 0, 3'd3, xr(8'h9A), 0, 0);
    vecs[5]  = mk(0, 8'h00, 1, 1, 8'h30, 1, 0, 3'd3, xr(8'h9A), 0, 0);
    vecs[6]  = mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 3'd3, xr(8'h9A), 0, 0);
    vecs[7]  = mk(1, 8'h00, 0, 0, 8'h00, 1, 1, 3'd0, 8'h00,     0, 0);
    vecs[8]  = mk(1, 8'h48, 0, 0, 8'h00, 1, 0, 3'd0, 8'h00,     1, 0);
    vecs[9]  = mk(1, 8'h01, 0, 0, 8'h00, 1, 0, 3'd0, 8'h00,     0, 0);
    vecs[10] = mk(1, 8'hFF, 0, 1, 8'hFF, 1, 1, 3'd1, xr(8'hFF), 0, 0);
    vecs[11] = mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 3'd1, xr(8'hFF), 0, 0);
    vecs[12] = mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 3'd1, xr(8'hFF), 0, 0);

    rst_n = 1'b0;
    push  = 1'b0;
    idata = 8'h00;
    pop   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 8'h00, 1, 0, 3'd0, 8'h00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: basic frame, pops, zero-length header, bad header, pop on empty.
    for (int i = 0; i < NVEC; i++) begin
      cycle(vecs[i].push, vecs[i].idata, vecs[i].pop);
      chk_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].odata, vecs[i].nf, vecs[i].fv,
              vecs[i].len, vecs[i].xr, vecs[i].he, vecs[i].ovf);
    end

    // Three 7-byte frames with no pops: the 17th payload byte overflows.
    mcnt = 0;
    movf = 1'b0;
    macc = 8'h00;
    for (int f = 0; f < 3; f++) begin
      cycle(1'b1, 8'h07, 1'b0);
      chk($sformatf("ovf.hdr%0d.hdr_err", f), {7'd0, hdr_err}, 8'h00);
      macc = 8'h00;
      for (int k = 0; k < 7; k++) begin
        j = 8'(f * 7 + k + 1);
        if (mcnt < 16) begin
          mcnt++;
          macc = macc ^ j;
        end else begin
          movf = 1'b1;
        end
        cycle(1'b1, j, 1'b0);
        chk($sformatf("ovf.b%0d.not_full", j), {7'd0, not_full}, {7'd0, mcnt < 16});
        chk($sformatf("ovf.b%0d.ovf_err", j),  {7'd0, ovf_err},  {7'd0, movf});
        chk($sformatf("ovf.b%0d.frm_valid", j), {7'd0, frm_valid}, {7'd0, k == 6});
        if (k == 6) begin
          chk($sformatf("ovf.f%0d.frm_len", f), {5'd0, frm_len}, 8'd7);
          chk($sformatf("ovf.f%0d.frm_xor", f), frm_xor, xr(macc));
        end
      end
    end
    chk("ovf.odata", odata, 8'h01);

    // Header accepted while full, then push+pop on full FIFO: push rejected.
    cycle(1'b1, 8'h02, 1'b0);
    chk("full.hdr.hdr_err",  {7'd0, hdr_err},  8'h00);
    chk("full.hdr.not_full", {7'd0, not_full}, 8'h00);
    cycle(1'b1, 8'hEE, 1'b1);
    chk_all("full.pushpop", 1, 8'h02, 1, 0, 3'd7, xr(8'h1F), 0, 1);
    cycle(1'b1, 8'h77, 1'b0);
    chk_all("full.last", 1, 8'h02, 0, 1, 3'd2, xr(8'h77), 0, 1);

    // Reset mid-frame after 2 of 5 payload bytes.
    cycle(1'b1, 8'h05, 1'b0);
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("midrst.async", 0, 8'h00, 1, 0, 3'd0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    chk_all("midrst.held", 0, 8'h00, 1, 0, 3'd0, 8'h00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h02, 1'b0);
    chk_all("post.hdr", 0, 8'h00, 1, 0, 3'd0, 8'h00, 0, 0);
    cycle(1'b1, 8'h11, 1'b0);
    chk_all("post.b0", 1, 8'h11, 1, 0, 3'd0, 8'h00, 0, 0);
    cycle(1'b1, 8'h22, 1'b0);
    chk_all("post.b1", 1, 8'h11, 1, 1, 3'd2, xr(8'h33), 0, 0);
    cycle(1'b0, 8'h00, 1'b1);
    chk_all("post.pop", 1, 8'h22, 1, 0, 3'd2, xr(8'h33), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_rx.md
# frame_rx

Receive-side frame parser for the length-prefixed byte-push protocol used on the xorexec input port. A producer pushes a header byte (payload length) followed by that many payload bytes, throttled by a not-full flag. `frame_rx` strips the header, buffers payload bytes in an internal first-word-fall-through FIFO for a downstream rdy/pop consumer, and reports each completed frame with its length and XOR checksum. It sits directly behind the stimulus/producer and in front of the XOR execution datapath.

## Interface
- `DEPTH`, 16 — payload FIFO entries; power of two, minimum 8.
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset; synchronous deassertion is the producer's responsibility.
- `push`  in  1  — producer byte strobe; `idata` is valid when high.
- `idata`  in  8  — header or payload byte.
- `not_full`  out  1  — FIFO holds fewer than `DEPTH` entries (registered count).
- `pop`  in  1  — consumer removes the head entry.
- `rdy`  out  1  — FIFO non-empty.
- `odata`  out  8  — FIFO head, valid while `rdy` is high.
- `frm_valid`  out  1  — one-cycle pulse at frame completion.
- `frm_len`  out  3  — payload length of the completed frame, held until the next `frm_valid`.
- `frm_xor`  out  8  — XOR of the completed frame's payload, held until the next `frm_valid`.
- `hdr_err`  out  1  — one-cycle pulse when a malformed header is discarded.
- `ovf_err`  out  1  — sticky: a payload byte was pushed while full.

## Operation
- Two-state FSM: HDR, PAY. Reset state: HDR.
- HDR, push accepted:
  - `idata[7:3] != 0`: byte discarded, `hdr_err` pulses, stay in HDR.
  - `idata[2:0] == 0`: zero-length frame. `frm_valid` pulses with `frm_len=0`, `frm_xor=0`. Stay in HDR.
  - Otherwise: latch `len=idata[2:0]`, clear the remaining count and XOR accumulator, go to PAY.
- Headers are never written to the FIFO and are accepted even when the FIFO is full.
- PAY, push accepted with `not_full=1`:
  - Byte is written to the FIFO and XORed into the accumulator; the remaining count decrements.
  - On the last byte (count reaches 0): go to HDR, `frm_valid` pulses.
- PAY, push with `not_full=0`:
  - Byte dropped, `ovf_err` sets, the count still decrements, and the byte is excluded from the XOR.
  - The frame still completes, so framing stays aligned.
- Pop with `rdy=1` removes the head. Pop with `rdy=0` is ignored.
- Simultaneous push and pop: both take effect and the count is unchanged. Push acceptance always uses the registered `not_full`, so a push while full is rejected even if a pop occurs in the same cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. The count is `$clog2(DEPTH)+1` bits.

## Timing
- Reset values:
  - `not_full=1`, `rdy=0`, `odata=0`, `frm_valid=0`, `frm_len=0`, `frm_xor=0`, `hdr_err=0`, `ovf_err=0`.
  - FIFO empty, state HDR.
- Push sampled at edge N: the entry is visible on `rdy`/`odata` after edge N (1-cycle latency).
- `frm_valid` and `hdr_err` assert in the cycle after the edge that accepted the last payload byte or the offending header. `frm_len` and `frm_xor` update on that same edge.
- `not_full` and `rdy` are registered and reflect the count after each edge.
- Reset asserted mid-frame: FSM returns to HDR, FIFO is flushed, the partial frame is lost, and no `frm_valid` is issued.
- Back-to-back frames: a header may be pushed in the cycle after the last payload byte.

## Configuration
- `FRM_RX_XOR_EN` defined: the XOR accumulator is built and `frm_xor` reports the payload checksum.
- Not defined: the accumulator is removed and `frm_xor` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, push header 0x03 then 0xA5, 0x0F, 0x30 on consecutive cycles -> `frm_valid` pulse with `frm_len=3`, `frm_xor=0x9A`; popping yields 0xA5, 0x0F, 0x30, then `rdy=0`.
- Push header 0x00 -> `frm_valid` the next cycle with `frm_len=0`, `frm_xor=0`; FIFO stays empty.
- Push header 0x48 -> `hdr_err` pulse; FSM stays in HDR; following header 0x01, 0xFF -> `frm_len=1`, `frm_xor=0xFF`.
- `DEPTH=16`, no pops, push three 7-byte frames -> `not_full` falls after 16 payload bytes; byte 17 is dropped, `ovf_err=1`, and the third frame still produces `frm_valid` with `frm_len=7`.
- FIFO full with a push and a pop in the same cycle -> push rejected, count becomes 15, `not_full=1` the next cycle.
- Assert `rst_n=0` after 2 of 5 payload bytes -> all outputs return to reset values, no `frm_valid`; a new frame after release parses correctly.
